// File: rtl/ab_seq_pkg.sv
// Shared types and defaults for the valid/a/b sequence transmitter.
package ab_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    DRAIN
  } ab_state_t;

  localparam int AB_DELAY_DEF = 3;
  localparam int AB_LEN_W_DEF = 4;

endpackage

// File: rtl/ab_delay_line.sv
// Fixed-depth shift register carrying each beat's b token.
module ab_delay_line
  import ab_seq_pkg::*;
#(
  parameter int DEPTH = AB_DELAY_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] sr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr <= '0;
    end else begin
      sr[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        sr[i] <= sr[i-1];
      end
    end
  end

  assign q = sr[DEPTH-1];

endmodule

// File: rtl/ab_seq_tx.sv
// Burst generator: len beats of valid/a, each followed by b DELAY cycles later.
module ab_seq_tx
  import ab_seq_pkg::*;
#(
  parameter int DELAY = AB_DELAY_DEF,
  parameter int LEN_W = AB_LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             inj_err,
  output logic             busy,
  output logic             valid,
  output logic             a,
  output logic             b,
  output logic             done
);

  localparam int DW = $clog2(DELAY + 1);

  ab_state_t        state;
  logic [LEN_W-1:0] beat_cnt;
  logic [DW-1:0]    drain_cnt;
  logic             tok;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      drain_cnt <= '0;
      busy      <= 1'b0;
      valid     <= 1'b0;
      a         <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && len != '0) begin
            state    <= BURST;
            beat_cnt <= len;
            busy     <= 1'b1;
            valid    <= 1'b1;
            a        <= 1'b1;
          end
        end
        BURST: begin
          beat_cnt <= beat_cnt - 1'b1;
          if (beat_cnt == LEN_W'(1)) begin
            state     <= DRAIN;
            drain_cnt <= DW'(DELAY);
            valid     <= 1'b0;
            a         <= 1'b0;
            // With DELAY==1 the first drain cycle is already the done slot.
            done      <= (DELAY == 1);
          end
        end
        DRAIN: begin
          drain_cnt <= drain_cnt - 1'b1;
          if (drain_cnt == DW'(2)) begin
            done <= 1'b1;
          end
          if (drain_cnt == DW'(1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          valid <= 1'b0;
          a     <= 1'b0;
        end
      endcase
    end
  end

  assign tok = (state == BURST) && !inj_err;

  ab_delay_line #(
    .DEPTH(DELAY)
  ) u_dly (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (tok),
    .q    (b)
  );

endmodule

// File: tb/tb_ab_seq_tx.sv
// Schedule-based model of ab_seq_tx with directed and random traffic.
module tb_ab_seq_tx;

  localparam int D  = 3;
  localparam int LW = 4;
  localparam int N  = 4000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [LW-1:0] len;
  logic          inj_err;
  logic          busy, valid, a, b, done;

  ab_seq_tx #(.DELAY(D), .LEN_W(LW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .len    (len),
    .inj_err(inj_err),
    .busy   (busy),
    .valid  (valid),
    .a      (a),
    .b      (b),
    .done   (done)
  );

  always #5 clk = ~clk;

  bit ev[N];
  bit eb[N];
  bit ebusy[N];
  bit edone[N];
  bit hv[N];
  int cyc;
  int errs;
  int checks;
  int misses;
  bit run;

  function automatic void chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (run) begin
      chk("valid", int'(valid), int'(ev[cyc]));
      chk("a", int'(a), int'(ev[cyc]));
      chk("b", int'(b), int'(eb[cyc]));
      chk("busy", int'(busy), int'(ebusy[cyc]));
      chk("done", int'(done), int'(edone[cyc]));
      hv[cyc] = valid;
      if (cyc >= D && hv[cyc-D] && !b) misses++;
    end
  end

  task automatic step(input bit s, input int l, input bit ie, input bit r);
    start   = s;
    len     = LW'(l);
    inj_err = ie;
    rst_n   = r;
    if (!r) begin
      for (int i = cyc + 1; i < N; i++) begin
        ev[i] = 0; eb[i] = 0; ebusy[i] = 0; edone[i] = 0;
      end
    end else begin
      if (ie && ev[cyc]) eb[cyc+D] = 0;
      if (s && l != 0 && !ebusy[cyc]) begin
        for (int k = 1; k <= l; k++) begin
          ev[cyc+k] = 1;
          eb[cyc+k+D] = 1;
        end
        for (int k = 1; k <= l + D; k++) ebusy[cyc+k] = 1;
        edone[cyc+l+D] = 1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 1);
  endtask

  initial begin
    int s;
    int cnt;
    errs = 0; checks = 0; cyc = 0; run = 0; misses = 0;
    rst_n = 0; start = 0; len = '0; inj_err = 0;
    repeat (3) @(posedge clk);
    #1;
    run = 1;
    step(0, 0, 0, 0);
    idle(2);

    s = cyc;
    step(1, 1, 0, 1);
    idle(7);
    chk("m1_v1", int'(ev[s+1]), 1);
    chk("m1_v2", int'(ev[s+2]), 0);
    chk("m1_b4", int'(eb[s+4]), 1);
    chk("m1_done4", int'(edone[s+4]), 1);
    chk("m1_busy5", int'(ebusy[s+5]), 0);

    misses = 0;
    s = cyc;
    step(1, 5, 0, 1);
    idle(10);
    chk("m2_b8", int'(eb[s+8]), 1);
    chk("m2_done8", int'(edone[s+8]), 1);
    chk("chk_pass5", misses, 0);

    misses = 0;
    s = cyc;
    step(1, 4, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 1, 1);
    idle(10);
    chk("m3_b4", int'(eb[s+4]), 1);
    chk("m3_b5", int'(eb[s+5]), 0);
    chk("m3_b6", int'(eb[s+6]), 1);
    chk("m3_done7", int'(edone[s+7]), 1);
    chk("chk_one_fail", misses, 1);

    s = cyc;
    step(1, 0, 0, 1);
    idle(4);
    chk("m4_len0", int'(ebusy[s+1]), 0);
    s = cyc;
    step(1, 3, 0, 1);
    idle(2);
    step(1, 7, 0, 1);
    idle(10);
    cnt = 0;
    for (int i = s; i < cyc; i++) cnt += int'(ev[i]);
    chk("m4_vcount", cnt, 3);

    s = cyc;
    step(1, 6, 0, 1);
    idle(2);
    step(0, 0, 0, 0);
    idle(1);
    step(1, 2, 0, 1);
    idle(10);
    chk("m5_b4", int'(eb[s+4]), 0);
    chk("m5_v6", int'(ev[s+6]), 1);
    chk("m5_v8", int'(ev[s+8]), 0);
    chk("m5_b9", int'(eb[s+9]), 1);
    chk("m5_b10", int'(eb[s+10]), 1);
    chk("m5_nodone9", int'(edone[s+9]), 0);

    s = cyc;
    for (int i = 0; i < 45; i++) step(1, 15, 0, 1);
    idle(20);
    chk("m6_done18", int'(edone[s+18]), 1);
    chk("m6_v19", int'(ev[s+19]), 0);
    chk("m6_v20", int'(ev[s+20]), 1);
    chk("m6_b20", int'(eb[s+20]), 0);

    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(3) == 0, int'($urandom_range(15)),
           $urandom_range(4) == 0, $urandom_range(49) != 0);
    end
    idle(25);

    run = 0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/ab_seq_tx.md
# ab_seq_tx

Transmit-side generator for the valid/a/b sequence protocol: on each accepted start command it emits a burst of `len` consecutive beats. Each beat drives `valid=1` and `a=1`, and `b=1` follows exactly DELAY cycles later. Any compliant checker of the form `valid |-> a ##DELAY b` must pass on every beat. The block sits in front of the protocol checker as the stimulus/traffic source, and provides an error-injection input so the checker's fail path can be exercised.

## Interface
- DELAY, 3, cycles from a beat's `a` to its `b`; legal range 1..15
- LEN_W, 4, width of burst-length field; maximum burst is 2^LEN_W-1 beats
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  burst request; sampled only in IDLE
- len  in  LEN_W  beats in burst; captured with start; `len==0` rejects the request
- inj_err  in  1  when high during a beat cycle, that beat's `b` is suppressed
- busy  out  1  high whenever state is not IDLE
- valid  out  1  beat qualifier
- a  out  1  sequence head; equals `valid`
- b  out  1  sequence tail, DELAY cycles after each non-corrupted beat
- done  out  1  one-cycle pulse coincident with the last beat's `b` slot

## Operation
- FSM states: IDLE, BURST, DRAIN.
- IDLE:
  - `start && len!=0` → load `beat_cnt=len`, go to BURST.
  - `start && len==0` → stay in IDLE; no output activity.
- BURST:
  - `valid=a=1` every cycle; `beat_cnt` decrements each cycle.
  - When `beat_cnt==1` the beat is the last one; the next state is DRAIN with `drain_cnt=DELAY`.
- DRAIN:
  - `valid=a=0`; `drain_cnt` decrements each cycle.
  - `done=1` in the cycle `drain_cnt==1`; the next state is IDLE.
- Delay line:
  - DELAY-deep shift register; stage 0 loads `(state==BURST) && !inj_err`.
  - `b` is the output of the last stage.
  - The line shifts every cycle in every state.
- `start` while `busy=1` is ignored; no queueing.
- `inj_err` only affects beats launched in the same cycle. It never affects `valid` or `a`.
- All outputs are registered.
- Arithmetic:
  - `beat_cnt` is LEN_W bits, unsigned.
  - `drain_cnt` is `$clog2(DELAY+1)` bits.
  - Neither counter wraps: BURST exits at 1, DRAIN exits at 1.

## Timing
- Reset values: `busy=0`, `valid=0`, `a=0`, `b=0`, `done=0`; state=IDLE; counters and delay line all zero.
- `start` sampled at edge of cycle 0 → first beat at cycle 1 → beat k (1..len) at cycle k.
- `b` for beat k appears at cycle k+DELAY.
- `done` is asserted at cycle len+DELAY. `busy` is high for cycles 1..len+DELAY.
- Earliest next accepted `start` is in cycle len+DELAY+1, i.e. sampled in the first IDLE cycle after `done`. This gives at least DELAY idle cycles between bursts.
- `rst_n=0` mid-burst or mid-drain: at the next edge, all outputs are 0, the FSM is in IDLE, and the delay line is cleared. Pending `b` values are discarded and no `done` is issued.
- `start` and `rst_n=0` in the same cycle: reset wins; the request is dropped.

## Structure
- Package `ab_seq_pkg`:
  - `typedef enum logic [1:0] {IDLE, BURST, DRAIN} ab_state_t`
  - localparams `AB_DELAY_DEF=3` and `AB_LEN_W_DEF=4`
- Sub-module `ab_delay_line` (parameter DEPTH):
  - ports `clk`, `rst_n`, `d`, `q`
  - synchronous clear on `rst_n=0`
  - instantiated once, with DEPTH=DELAY

## Test plan
- Reset then `start=1, len=1`:
  - `valid/a` high in cycle 1 only
  - `b` high in cycle 4
  - `done` in cycle 4
  - `busy` high in cycles 1..4
- `start=1, len=5`, DELAY=3:
  - `valid` high in cycles 1..5
  - `b` high in cycles 4..8
  - `done` in cycle 8
  - bound assertion `valid |-> a ##3 b` passes on all 5 beats
- `len=4` with `inj_err=1` in cycle 2 only:
  - `b` high in cycles 4, 6, 7
  - `b` low in cycle 5
  - checker reports exactly one fail
  - `done` still at cycle 7
- `len=0`: `busy` stays 0 and no output toggles. Second `start` pulsed in cycle 3 of a `len=3` burst: ignored, `valid` count equals 3.
- `len=6` with `rst_n=0` in cycle 3:
  - all outputs 0 from cycle 4
  - no `b` pulses afterwards
  - no `done`
  - new `start` in cycle 5 with `len=2` gives `valid` in cycles 6..7 and `b` in cycles 9..10
- `len=15` (max), then `start` held high continuously:
  - first burst `done` at cycle 18
  - second burst starts at cycle 20 (start sampled at cycle 19)
  - no overlap of `b` pulses between bursts
